// File: rtl/edge_detect_multi_if.sv
// Signal bundle between board-level inputs and the multi-channel edge detector.
// Direction suffixes are from the detector's point of view.
interface edge_detect_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       in_i;
  logic [1:0]          mode_i;
  logic [CH-1:0]       clr_i;
  logic [CH-1:0]       level_o;
  logic [CH-1:0]       pulse_o;
  logic [CH-1:0]       flag_o;
  logic [CH*CNT_W-1:0] count_o;
  logic                irq_o;

  modport master (
    output in_i, mode_i, clr_i,
    input  level_o, pulse_o, flag_o, count_o, irq_o
  );

  modport slave (
    input  in_i, mode_i, clr_i,
    output level_o, pulse_o, flag_o, count_o, irq_o
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise + debounce + edge detector with sticky flags,
// saturating event counters and a combined interrupt.
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter bit INIT        = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  edge_detect_multi_if.slave  bus
);

  localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               TOP      = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q  [CH];
  logic [SYNC_STAGES-1:0] sync_d  [CH];
  logic [DEB_W-1:0]       deb_q   [CH];
  logic [DEB_W-1:0]       deb_d   [CH];
  logic [CNT_W-1:0]       count_q [CH];
  logic [CNT_W-1:0]       count_d [CH];
  logic [CH-1:0]          level_q, level_d;
  logic [CH-1:0]          pulse_q, pulse_d;
  logic [CH-1:0]          flag_q,  flag_d;

  always_comb begin
    // NOTE: every next-state variable gets a default before any branch, so no latch is inferred.
    for (int i = 0; i < CH; i++) begin
      sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], bus.in_i[i]};
      level_d[i] = level_q[i];
      deb_d[i]   = '0;
      pulse_d[i] = 1'b0;

      if (sync_q[i][TOP] != level_q[i]) begin
        if (deb_q[i] == DEB_LAST) begin
          level_d[i] = sync_q[i][TOP];
          // mode is looked at only on the accepting edge; bit 0 = rising, bit 1 = falling
          pulse_d[i] = sync_q[i][TOP] ? bus.mode_i[0] : bus.mode_i[1];
        end else begin
          deb_d[i] = deb_q[i] + DEB_W'(1);
        end
      end

      flag_d[i] = pulse_q[i] | (flag_q[i] & ~bus.clr_i[i]);

      if (bus.clr_i[i]) begin
        count_d[i] = pulse_q[i] ? CNT_W'(1) : '0;
      end else if (pulse_q[i] && (count_q[i] != CNT_MAX)) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else begin
        count_d[i] = count_q[i];
      end
    end
  end

  // NOTE: the per-channel arrays are small registers, not RAM, so they are reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i]  <= {SYNC_STAGES{INIT}};
        deb_q[i]   <= '0;
        count_q[i] <= '0;
      end
      level_q <= {CH{INIT}};
      pulse_q <= '0;
      flag_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
      for (int i = 0; i < CH; i++) begin
        sync_q[i]  <= sync_d[i];
        deb_q[i]   <= deb_d[i];
        count_q[i] <= count_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_count
    assign bus.count_o[g*CNT_W +: CNT_W] = count_q[g];
  end

  assign bus.level_o = level_q;
  assign bus.pulse_o = pulse_q;
  assign bus.flag_o  = flag_q;
  assign bus.irq_o   = |flag_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (CH=4, 2 sync stages, 4-cycle debounce,
// 2-bit counters so saturation is reachable quickly).
module tb_edge_detect_multi;

  localparam int CH    = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  int   pulse_cnt [CH];
  logic low_seen  [CH];
  logic last_lvl  [CH];

  edge_detect_multi_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

  edge_detect_multi #(
    .CH(CH), .SYNC_STAGES(2), .DEB_CYCLES(4), .CNT_W(CNT_W), .INIT(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run n cycles, recording per-channel pulse counts, whether level went low,
  // and the level seen alongside the most recent pulse.
  task automatic watch(input int n);
    for (int c = 0; c < CH; c++) begin
      pulse_cnt[c] = 0;
      low_seen[c]  = 1'b0;
      last_lvl[c]  = 1'bx;
    end
    repeat (n) begin
      tick(1);
      for (int c = 0; c < CH; c++) begin
        if (bus.pulse_o[c]) begin
          pulse_cnt[c]++;
          last_lvl[c] = bus.level_o[c];
        end
        if (!bus.level_o[c]) low_seen[c] = 1'b1;
      end
    end
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int c = 0; c < CH; c++) t += pulse_cnt[c];
    return t;
  endfunction

  initial begin
    int sum;
    bus.in_i   = 4'hF;
    bus.mode_i = 2'b00;
    bus.clr_i  = '0;

    // Reset values while reset is held
    tick(2);
    check("rst_level", 32'(bus.level_o), 32'hF);
    check("rst_pulse", 32'(bus.pulse_o), 32'h0);
    check("rst_count", 32'(bus.count_o), 32'h0);
    check("rst_irq",   32'(bus.irq_o),   32'h0);

    // Release with inputs at idle: nothing happens for 20 cycles
    rst = 1'b0;
    watch(20);
    check("idle_pulses", 32'(total_pulses()), 32'd0);
    check("idle_level",  32'(bus.level_o), 32'hF);
    check("idle_flag",   32'(bus.flag_o),  32'h0);
    check("idle_count",  32'(bus.count_o), 32'h0);

    // Falling edge on ch0, mode=10: level/pulse at edge k+5, flag/count one later
    bus.mode_i = 2'b10;
    bus.in_i[0] = 1'b0;
    tick(5);
    check("fall_k4_pulse", 32'(bus.pulse_o), 32'h0);
    check("fall_k4_level", 32'(bus.level_o), 32'hF);
    tick(1);
    check("fall_k5_pulse", 32'(bus.pulse_o), 32'h1);
    check("fall_k5_level", 32'(bus.level_o), 32'hE);
    check("fall_k5_flag",  32'(bus.flag_o),  32'h0);
    tick(1);
    check("fall_k6_pulse", 32'(bus.pulse_o), 32'h0);
    check("fall_k6_flag",  32'(bus.flag_o),  32'h1);
    check("fall_k6_count", 32'(bus.count_o), 32'h01);
    check("fall_k6_irq",   32'(bus.irq_o),   32'h1);

    // 3-cycle glitch on ch1 is rejected
    bus.in_i[1] = 1'b0;
    tick(3);
    bus.in_i[1] = 1'b1;
    watch(15);
    check("glitch3_pulses", 32'(pulse_cnt[1]), 32'd0);
    check("glitch3_low",    32'(low_seen[1]),  32'd0);

    // 4-cycle low is accepted: one falling pulse, rising edge not reported in mode=10
    bus.in_i[1] = 1'b0;
    tick(4);
    bus.in_i[1] = 1'b1;
    watch(20);
    check("low4_pulses", 32'(pulse_cnt[1]),      32'd1);
    check("low4_low",    32'(low_seen[1]),       32'd1);
    check("low4_level",  32'(bus.level_o[1]),    32'd1);
    check("low4_count",  32'(bus.count_o[3:2]),  32'd1);
    check("low4_flag",   32'(bus.flag_o),        32'h3);

    // mode=11 on ch2: both edges give a pulse
    bus.mode_i = 2'b11;
    bus.in_i[2] = 1'b0;
    watch(10);
    check("both_fall", 32'(pulse_cnt[2]), 32'd1);
    bus.in_i[2] = 1'b1;
    watch(10);
    check("both_rise",  32'(pulse_cnt[2]),     32'd1);
    check("both_count", 32'(bus.count_o[5:4]), 32'd2);

    // mode=01: only the 0->1 transition pulses
    bus.mode_i = 2'b01;
    bus.in_i[2] = 1'b0;
    watch(10);
    check("rise_only_fall", 32'(pulse_cnt[2]), 32'd0);
    check("rise_only_lvl",  32'(bus.level_o[2]), 32'd0);
    bus.in_i[2] = 1'b1;
    watch(10);
    check("rise_only_rise",  32'(pulse_cnt[2]),     32'd1);
    check("rise_only_dir",   32'(last_lvl[2]),      32'd1);
    check("rise_only_count", 32'(bus.count_o[5:4]), 32'd3);

    // Five accepted edges on ch3 saturate a 2-bit counter at 3
    bus.mode_i = 2'b11;
    sum = 0;
    for (int e = 0; e < 5; e++) begin
      bus.in_i[3] = ~bus.in_i[3];
      watch(8);
      sum += pulse_cnt[3];
    end
    check("sat_pulses", 32'(sum),              32'd5);
    check("sat_count",  32'(bus.count_o[7:6]), 32'd3);
    check("sat_flag",   32'(bus.flag_o[3]),    32'd1);

    // clr in the same cycle as pulse: count restarts at 1, flag stays set
    bus.in_i[3] = 1'b1;
    tick(6);
    check("clr_pulse_seen", 32'(bus.pulse_o), 32'h8);
    bus.clr_i[3] = 1'b1;
    tick(1);
    bus.clr_i[3] = 1'b0;
    check("clr_pulse_count", 32'(bus.count_o[7:6]), 32'd1);
    check("clr_pulse_flag",  32'(bus.flag_o[3]),    32'd1);

    // Plain clear of ch0 leaves other channels untouched
    bus.clr_i[0] = 1'b1;
    tick(1);
    bus.clr_i[0] = 1'b0;
    check("clr_flags", 32'(bus.flag_o),  32'hE);
    check("clr_count", 32'(bus.count_o), 32'h74);
    check("clr_irq",   32'(bus.irq_o),   32'h1);

    // Reset two cycles into a pending rise on ch0
    bus.in_i[0] = 1'b1;
    tick(4);
    check("pend_level", 32'(bus.level_o[0]), 32'd0);
    check("pend_pulse", 32'(bus.pulse_o),    32'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_level", 32'(bus.level_o), 32'hF);
    check("mid_rst_pulse", 32'(bus.pulse_o), 32'h0);
    check("mid_rst_flag",  32'(bus.flag_o),  32'h0);
    check("mid_rst_count", 32'(bus.count_o), 32'h0);
    check("mid_rst_irq",   32'(bus.irq_o),   32'h0);
    tick(1);
    rst = 1'b0;
    watch(20);
    check("post_rst_pulses", 32'(total_pulses()), 32'd0);

    // A complete new debounce after reset does pulse, with normal latency
    bus.in_i[0] = 1'b0;
    tick(5);
    check("post_rst_k4", 32'(bus.pulse_o), 32'h0);
    tick(1);
    check("post_rst_k5", 32'(bus.pulse_o), 32'h1);
    tick(1);
    check("post_rst_cnt", 32'(bus.count_o), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector replacing single-input, fixed-polarity edge detection. Each channel synchronises an asynchronous input (push-button or external line), debounces it, and produces a one-cycle event pulse on rising, falling or both edges according to a runtime mode. Each channel also keeps a sticky event flag and a saturating event counter. The block sits between board-level inputs and the control FSMs/timers that consume button presses.

## Interface
Parameters:
- CH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEB_CYCLES, 4: consecutive cycles a new synchronised level must persist before acceptance (≥1)
- CNT_W, 8: width of each per-channel event counter (≥1)
- INIT, 1: idle level of inputs; reset value of synchroniser flops and debounced level

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in  in  CH  raw asynchronous inputs
- mode  in  2  global edge select: 00 none, 01 rising, 10 falling, 11 both
- clr  in  CH  per-channel synchronous clear of flag and count
- level  out  CH  debounced level
- pulse  out  CH  one-cycle edge event
- flag  out  CH  sticky event flag
- count  out  CH*CNT_W  per-channel event counters; channel i in bits [i*CNT_W +: CNT_W]
- irq  out  1  OR of all flag bits

## Operation
- Reset (rst high, asynchronous): sync chain and level = INIT per bit; debounce counters = 0; pulse = 0; flag = 0; count = 0; irq = 0. No pulse may be generated by reset release alone, even if in differs from INIT; that difference is treated as a normal edge after debounce.
- Synchroniser: SYNC_STAGES-deep shift of in[i]; last stage is s[i].
- Debounce, per channel, every clock:
  - s == level: deb counter ← 0.
  - s != level and deb counter == DEB_CYCLES-1: level ← s; deb counter ← 0; accepted edge (rising if s=1, falling if s=0).
  - otherwise deb counter ← deb counter + 1.
  - A glitch shorter than DEB_CYCLES synchronised cycles never changes level, so it restarts the count.
- Event: pulse[i] ← accepted edge AND mode selects its direction; otherwise 0. Pulse is registered and high for exactly one cycle per accepted edge. level tracks the input whatever the mode is.
- mode is sampled on the same edge that accepts the level change; no synchronisation is done on mode.
- Flag: set when pulse[i] is written 1; cleared by clr[i]; simultaneous set and clr leaves flag = 1.
- Count: +1 on each pulse, saturating at 2^CNT_W−1 (no wrap); clr[i] → 0; simultaneous clr and pulse → 1.
- irq: combinational OR of the flag registers.
- Channels are fully independent; simultaneous events on several channels are all recorded.

## Timing
- Let edge k be the first clock edge that captures a new in value, with the value held stable afterwards. Then level and pulse update at edge k+SYNC_STAGES+DEB_CYCLES−1. With defaults, that is edge k+5.
- flag and count update one edge after pulse goes high, i.e. they are visible in the cycle after the pulse cycle.
- Minimum spacing between accepted edges on one channel is DEB_CYCLES cycles.
- If rst is asserted mid-debounce, all state returns to reset values immediately. No pulse is emitted for a partially debounced edge.

## Test plan
- Reset release with in=all 1, then hold for 20 cycles → pulse, flag and count stay 0; level=4'b1111.
- Defaults, mode=10: drive in[0] 1→0 at edge k and hold → pulse[0] high only in the cycle after edge k+5, then flag[0]=1, count0=1, irq=1.
- Glitch: in[1] low for 3 cycles, then high again → level[1] stays 1, no pulse. A 4-cycle low → exactly one pulse with mode=10.
- mode=11, toggle in[2] 1→0→1 with 10-cycle holds → two pulses, count2=2. With mode=01 the same stimulus gives one pulse, on the 0→1 transition.
- CNT_W=2: apply 5 accepted edges on ch3 → count3 sticks at 3. Then assert clr[3] in the same cycle as pulse[3] → count3=1, flag[3]=1.
- Assert rst at DEB_CYCLES−2 into a pending change → outputs at reset values immediately; no pulse afterwards until a full new debounce completes.
